// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one bit of the weight per cycle, signed or unsigned
// per transaction, with optional accumulation into the result register M.
module seq_multiplier #(
  parameter int FEAT_BIT   = 16,
  parameter int WEIGHT_BIT = 8,
  parameter int OUT_BIT    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FEAT_BIT-1:0]   A,
  input  logic [WEIGHT_BIT-1:0] B,
  input  logic                  is_signed,
  input  logic                  acc_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_BIT-1:0]    M
);

  localparam int CNT_W = (WEIGHT_BIT > 1) ? $clog2(WEIGHT_BIT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (OUT_BIT < FEAT_BIT + WEIGHT_BIT) begin : g_width_check
      $error("seq_multiplier: OUT_BIT must be >= FEAT_BIT + WEIGHT_BIT");
    end
  endgenerate

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [FEAT_BIT-1:0]   a_q;
  logic [WEIGHT_BIT-1:0] b_q;
  logic                  sgn_q;
  logic signed [OUT_BIT-1:0] m_q;
  logic                  last_step;

  // The weight's MSB carries negative weight in two's complement, so it subtracts.
  function automatic logic signed [OUT_BIT-1:0] shift_add_step(
    input logic signed [OUT_BIT-1:0] acc,
    input logic [FEAT_BIT-1:0]       a,
    input logic                      sgn,
    input logic [CNT_W-1:0]          idx,
    input logic                      msb
  );
    logic signed [OUT_BIT-1:0] a_ext;
    logic signed [OUT_BIT-1:0] addend;
    a_ext  = sgn ? OUT_BIT'(signed'(a)) : OUT_BIT'(a);
    addend = a_ext << idx;
    return (msb && sgn) ? acc - addend : acc + addend;
  endfunction

  assign last_step = (cnt == CNT_W'(WEIGHT_BIT - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign M         = m_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      m_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            sgn_q <= is_signed;
            cnt   <= '0;
            if (!acc_en) m_q <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (b_q[cnt]) m_q <= shift_add_step(m_q, a_q, sgn_q, cnt, last_step);
          if (last_step) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: vector table plus backpressure, reset and wrap sequences.
module tb_seq_multiplier;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic        is_signed = 0;
  logic        acc_en = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] M;

  int total = 0;
  int bad   = 0;

  seq_multiplier #(.FEAT_BIT(16), .WEIGHT_BIT(8), .OUT_BIT(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .is_signed(is_signed), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready), .M(M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        acc;
    logic [15:0] a;
    logic [7:0]  b;
    logic [31:0] exp_m;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input logic s, input logic acc);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1; A = a; B = b; is_signed = s; acc_en = acc;
    @(posedge clk);
    #1 in_valid = 0;
    A = $urandom; B = $urandom; is_signed = $urandom; acc_en = $urandom;
  endtask

  task automatic wait_done(output logic [31:0] m, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    m = M;
  endtask

  task automatic consume();
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic s,
                        input logic acc, output logic [31:0] m);
    int lat;
    start_op(a, b, s, acc);
    wait_done(m, lat);
    check("latency", 32'(lat), 32'd8);
    consume();
  endtask

  initial begin
    logic [31:0] m, ref_m, held;
    int lat;
    bit pulse_seen;

    vecs[0] = '{1'b1, 1'b0, 16'hFFFD, 8'hFB, 32'h0000000F};
    vecs[1] = '{1'b1, 1'b0, 16'h8000, 8'h80, 32'h00400000};
    vecs[2] = '{1'b1, 1'b0, 16'h7FFF, 8'h81, 32'hFFC0807F};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 8'hFF, 32'h00FEFF01};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 8'hFF, 32'h00000001};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFD, 8'hFB, 32'h0000000F};
    vecs[6] = '{1'b1, 1'b1, 16'h0002, 8'h03, 32'h00000015};
    vecs[7] = '{1'b0, 1'b0, 16'h1234, 8'h01, 32'h00001234};
    vecs[8] = '{1'b1, 1'b0, 16'h8000, 8'h7F, 32'hFFC08000};
    vecs[9] = '{1'b0, 1'b1, 16'h0001, 8'h01, 32'hFFC08001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_M", M, 32'd0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].acc, m);
      check($sformatf("vec%0d_M", i), m, vecs[i].exp_m);
    end

    // Wrap-around accumulation against a 32-bit reference
    ref_m = M;
    for (int i = 0; i < 1100; i++) begin
      start_op(16'h7FFF, 8'h7F, 1'b1, 1'b1);
      wait_done(m, lat);
      if (lat != 8) check("wrap_latency", 32'(lat), 32'd8);
      ref_m = ref_m + 32'd4161409;
      @(negedge clk) out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
    end
    check("wrap_accum_M", M, ref_m);

    // Backpressure in DONE
    start_op(16'h0007, 8'h09, 1'b0, 1'b0);
    wait_done(m, lat);
    check("bp_latency", 32'(lat), 32'd8);
    check("bp_M", m, 32'd63);
    held = m;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); A = 16'h1111; B = 8'h22; acc_en = 0;
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_M", i), M, held);
      check($sformatf("bp_hold%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk) in_valid = 0;
    consume();
    @(posedge clk);
    #1;
    check("bp_idle_after_release", 32'(in_ready), 32'd1);
    check("bp_M_after_release", M, held);

    // Reset three steps into BUSY
    start_op(16'h1234, 8'hFF, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_M", M, 32'd0);
    @(negedge clk) rst_n = 1;
    pulse_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (out_valid) pulse_seen = 1;
    end
    check("midrst_no_out_pulse", 32'(pulse_seen), 32'd0);
    run_op(16'h0002, 8'h03, 1'b0, 1'b1, m);
    check("post_rst_M", m, 32'h00000006);

    // Reset wins over a simultaneous in_valid
    @(negedge clk);
    rst_n = 0; in_valid = 1; A = 16'h0005; B = 8'h05; is_signed = 0; acc_en = 0;
    @(posedge clk);
    #1;
    check("rst_vs_valid_in_ready", 32'(in_ready), 32'd1);
    check("rst_vs_valid_M", M, 32'd0);
    @(negedge clk);
    in_valid = 0; rst_n = 1;
    repeat (10) @(posedge clk);
    #1 check("rst_vs_valid_no_op", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
